// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: load-use bubbles,
// branch/jump flushes and data-memory wait freezes, with saturating statistics.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RsIF2ID,
    input  logic [4:0]       RtIF2ID,
    input  logic             UsesRtIF2ID,
    input  logic [4:0]       RtID2EX,
    input  logic             MemReadID2EX,
    input  logic             BranchTakenID,
    input  logic             JumpID,
    input  logic             MemReqEX2MEM,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IF2IDWrite,
    output logic             IF2IDFlush,
    output logic             ID2EXFlush,
    output logic             PipeFreeze,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] LoadUseCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic [CNT_W-1:0] MemWaitCount
);

    // Wide enough to hold TIMEOUT itself, where the wait counter saturates.
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MEMWAIT
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_REDIRECT,
        SEL_LOADUSE,
        SEL_MEMWAIT
    } hazard_t;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic              memwait;
    logic              loaduse;
    logic              redirect;
    hazard_t           hazard;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        memwait  = MemReqEX2MEM && !MemReady;
        loaduse  = MemReadID2EX && (RtID2EX != 5'd0) &&
                   ((RtID2EX == RsIF2ID) || (UsesRtIF2ID && (RtID2EX == RtIF2ID)));
        redirect = BranchTakenID || JumpID;
    end

    // A pending redirect is dropped under a stall: the branch stays in ID and
    // re-resolves once the stall has cleared.
    always_comb begin
        if (memwait)
            hazard = SEL_MEMWAIT;
        else if (loaduse)
            hazard = SEL_LOADUSE;
        else if (redirect)
            hazard = SEL_REDIRECT;
        else
            hazard = SEL_NONE;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        PCWrite    = 1'b1;
        IF2IDWrite = 1'b1;
        IF2IDFlush = 1'b0;
        ID2EXFlush = 1'b0;
        PipeFreeze = 1'b0;
        if (rst) begin
            PCWrite    = 1'b0;
            IF2IDWrite = 1'b0;
            IF2IDFlush = 1'b1;
            ID2EXFlush = 1'b1;
        end else begin
            case (hazard)
                SEL_MEMWAIT: begin
                    PCWrite    = 1'b0;
                    IF2IDWrite = 1'b0;
                    PipeFreeze = 1'b1;
                end
                SEL_LOADUSE: begin
                    PCWrite    = 1'b0;
                    IF2IDWrite = 1'b0;
                    ID2EXFlush = 1'b1;
                end
                SEL_REDIRECT: IF2IDFlush = 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wcnt         <= '0;
            MemTimeout   <= 1'b0;
            LoadUseCount <= '0;
            FlushCount   <= '0;
            MemWaitCount <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (memwait) begin
                        state <= MEMWAIT;
                        wcnt  <= WCNT_ONE;
                    end
                end
                MEMWAIT: begin
                    if (!memwait) begin
                        state <= RUN;
                        wcnt  <= '0;
                    end else begin
                        if (wcnt != WCNT_MAX)
                            wcnt <= wcnt + WCNT_ONE;
                        if (wcnt == WCNT_LAST)
                            MemTimeout <= 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    wcnt  <= '0;
                end
            endcase

            if (hazard == SEL_LOADUSE)
                LoadUseCount <= sat_inc(LoadUseCount);
            if (hazard == SEL_REDIRECT)
                FlushCount <= sat_inc(FlushCount);
            if (memwait)
                MemWaitCount <= sat_inc(MemWaitCount);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a default instance and a small one
// (CNT_W=2, TIMEOUT=4) share stimulus and are compared to a behavioural model.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] rs_id, rt_id, rt_ex;
    logic       uses_rt, mem_read, br, jmp, mem_req, mem_ready;

    logic        pcw_a, ifw_a, iff_a, exf_a, frz_a, to_a;
    logic [15:0] lu_a, fl_a, mw_a;
    logic        pcw_b, ifw_b, iff_b, exf_b, frz_b, to_b;
    logic [1:0]  lu_b, fl_b, mw_b;
    logic [4:0]  ctrl_a, ctrl_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model state: unbounded event counts, consecutive wait length, sticky flags.
    int m_lu, m_fl, m_mw, m_run;
    bit m_to_a, m_to_b;

    hazard_ctrl dut_a (
        .clk(clk), .rst(rst), .RsIF2ID(rs_id), .RtIF2ID(rt_id), .UsesRtIF2ID(uses_rt),
        .RtID2EX(rt_ex), .MemReadID2EX(mem_read), .BranchTakenID(br), .JumpID(jmp),
        .MemReqEX2MEM(mem_req), .MemReady(mem_ready),
        .PCWrite(pcw_a), .IF2IDWrite(ifw_a), .IF2IDFlush(iff_a), .ID2EXFlush(exf_a),
        .PipeFreeze(frz_a), .MemTimeout(to_a),
        .LoadUseCount(lu_a), .FlushCount(fl_a), .MemWaitCount(mw_a)
    );

    hazard_ctrl #(.CNT_W(2), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .RsIF2ID(rs_id), .RtIF2ID(rt_id), .UsesRtIF2ID(uses_rt),
        .RtID2EX(rt_ex), .MemReadID2EX(mem_read), .BranchTakenID(br), .JumpID(jmp),
        .MemReqEX2MEM(mem_req), .MemReady(mem_ready),
        .PCWrite(pcw_b), .IF2IDWrite(ifw_b), .IF2IDFlush(iff_b), .ID2EXFlush(exf_b),
        .PipeFreeze(frz_b), .MemTimeout(to_b),
        .LoadUseCount(lu_b), .FlushCount(fl_b), .MemWaitCount(mw_b)
    );

    assign ctrl_a = {pcw_a, ifw_a, iff_a, exf_a, frz_a};
    assign ctrl_b = {pcw_b, ifw_b, iff_b, exf_b, frz_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {PCWrite, IF2IDWrite, IF2IDFlush, ID2EXFlush, PipeFreeze}.
    function automatic logic [4:0] model_ctrl();
        bit mw, lu, rd;
        if (rst) return 5'b00110;
        mw = mem_req && !mem_ready;
        lu = mem_read && rt_ex != 0 && (rt_ex == rs_id || (uses_rt && rt_ex == rt_id));
        rd = br || jmp;
        if (mw) return 5'b00001;
        if (lu) return 5'b00010;
        if (rd) return 5'b11100;
        return 5'b11000;
    endfunction

    function automatic int satc(int v, int w);
        int lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic drive_idle();
        rst = 0; rs_id = 0; rt_id = 0; rt_ex = 0; uses_rt = 0; mem_read = 0;
        br = 0; jmp = 0; mem_req = 0; mem_ready = 0;
    endtask

    // Advance one rising edge and move the model with the inputs sampled there.
    task automatic tick();
        logic [4:0] c;
        @(posedge clk);
        c = model_ctrl();
        if (rst) begin
            m_lu = 0; m_fl = 0; m_mw = 0; m_run = 0; m_to_a = 0; m_to_b = 0;
        end else begin
            if (c == 5'b00001) begin
                m_mw++;
                m_run++;
                if (m_run >= 64) m_to_a = 1;
                if (m_run >= 4)  m_to_b = 1;
            end else begin
                m_run = 0;
            end
            if (c == 5'b00010) m_lu++;
            if (c == 5'b11100) m_fl++;
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); drive_idle(); rst = 1; mem_req = 1; br = 1; #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b00110}})
            $display("FAIL reset_ctrl got %b/%b exp 00110", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
        @(negedge clk); drive_idle(); #1;
        total_cnt++;
        if ({lu_a, fl_a, mw_a, to_a, lu_b, fl_b, mw_b, to_b} !== '0)
            $display("FAIL reset_state got %h %h %h %b / %h %h %h %b exp all 0",
                     lu_a, fl_a, mw_a, to_a, lu_b, fl_b, mw_b, to_b);
        else pass_cnt++;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b11000}})
            $display("FAIL post_reset_ctrl got %b/%b exp 11000", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_load_use();
        @(negedge clk); drive_idle(); rt_ex = 5; mem_read = 1; rs_id = 5; #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b00010}})
            $display("FAIL load_use_ctrl got %b/%b exp 00010", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({lu_a, lu_b} !== {16'd1, 2'd1})
            $display("FAIL load_use_count got %0d/%0d exp 1/1", lu_a, lu_b);
        else pass_cnt++;
        @(negedge clk); drive_idle(); #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b11000}})
            $display("FAIL load_use_release got %b/%b exp 11000", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_no_stall();
        @(negedge clk); drive_idle(); rt_ex = 0; rs_id = 0; mem_read = 1; #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b11000}})
            $display("FAIL r0_no_stall got %b/%b exp 11000", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
        @(negedge clk); drive_idle(); rt_ex = 7; rt_id = 7; rs_id = 3; mem_read = 1; #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b11000}})
            $display("FAIL rt_unused_no_stall got %b/%b exp 11000", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
        @(negedge clk); uses_rt = 1; #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b00010}})
            $display("FAIL rt_used_stall got %b/%b exp 00010", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (lu_a !== 16'(m_lu) || m_lu != 2)
            $display("FAIL no_stall_count got %0d exp 2", lu_a);
        else pass_cnt++;
    endtask

    task automatic test_branch_vs_load_use();
        int fl0;
        fl0 = m_fl;
        @(negedge clk); drive_idle(); rt_ex = 9; rs_id = 9; mem_read = 1; br = 1; #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b00010}})
            $display("FAIL branch_under_stall got %b/%b exp 00010", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
        @(negedge clk); drive_idle(); br = 1; #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b11100}})
            $display("FAIL branch_flush got %b/%b exp 11100", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (fl_a !== 16'(fl0 + 1) || fl_b !== 2'(satc(fl0 + 1, 2)))
            $display("FAIL flush_count got %0d/%0d exp %0d", fl_a, fl_b, fl0 + 1);
        else pass_cnt++;
        @(negedge clk); drive_idle(); jmp = 1; #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b11100}})
            $display("FAIL jump_flush got %b/%b exp 11100", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_mem_wait();
        int mw0;
        mw0 = m_mw;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive_idle(); mem_req = 1; #1;
            total_cnt++;
            if ({ctrl_a, ctrl_b} !== {2{5'b00001}})
                $display("FAIL mem_wait_freeze%0d got %b/%b exp 00001", i, ctrl_a, ctrl_b);
            else pass_cnt++;
            tick();
        end
        @(negedge clk); mem_ready = 1; #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b11000}})
            $display("FAIL mem_wait_release got %b/%b exp 11000", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (mw_a !== 16'(mw0 + 3) || {to_a, to_b} !== 2'b00)
            $display("FAIL mem_wait_count got %0d to=%b%b exp %0d to=00", mw_a, to_a, to_b, mw0 + 3);
        else pass_cnt++;
    endtask

    task automatic test_ready_first();
        int mw0;
        mw0 = m_mw;
        @(negedge clk); drive_idle(); mem_req = 1; mem_ready = 1; #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b11000}})
            $display("FAIL ready_first_ctrl got %b/%b exp 11000", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (mw_a !== 16'(mw0))
            $display("FAIL ready_first_count got %0d exp %0d", mw_a, mw0);
        else pass_cnt++;
    endtask

    task automatic test_all_three();
        int lu0, fl0;
        lu0 = m_lu; fl0 = m_fl;
        @(negedge clk); drive_idle();
        mem_req = 1; rt_ex = 4; rs_id = 4; mem_read = 1; br = 1; #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b00001}})
            $display("FAIL all_three_ctrl got %b/%b exp 00001", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (lu_a !== 16'(lu0) || fl_a !== 16'(fl0))
            $display("FAIL all_three_counts got %0d/%0d exp %0d/%0d", lu_a, fl_a, lu0, fl0);
        else pass_cnt++;
        @(negedge clk); mem_ready = 1; #1;
        total_cnt++;
        if ({ctrl_a, ctrl_b} !== {2{5'b00010}})
            $display("FAIL all_three_after got %b/%b exp 00010", ctrl_a, ctrl_b);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk); drive_idle(); mem_req = 1; #1;
            total_cnt++;
            if ({ctrl_a, ctrl_b} !== {2{5'b00001}})
                $display("FAIL timeout_freeze%0d got %b/%b exp 00001", i, ctrl_a, ctrl_b);
            else pass_cnt++;
            tick();
            total_cnt++;
            if ({to_a, to_b} !== {1'b0, i >= 4})
                $display("FAIL timeout_flag%0d got %b%b exp 0%0d", i, to_a, to_b, i >= 4);
            else pass_cnt++;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); mem_ready = 1; #1;
            total_cnt++;
            if ({ctrl_b, to_b} !== {5'b11000, 1'b1})
                $display("FAIL timeout_sticky%0d got %b %b exp 11000 1", i, ctrl_b, to_b);
            else pass_cnt++;
            tick();
        end
        @(negedge clk); drive_idle(); rst = 1; #1;
        tick();
        @(negedge clk); drive_idle(); #1;
        total_cnt++;
        if ({to_a, to_b, lu_a, fl_a, mw_a, lu_b, fl_b, mw_b} !== '0)
            $display("FAIL timeout_reset got to=%b%b counts %0d %0d %0d exp 0",
                     to_a, to_b, lu_a, fl_a, mw_a);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive_idle(); rt_ex = 12; rs_id = 12; mem_read = 1; #1;
            tick();
            @(negedge clk); drive_idle(); #1;
            tick();
        end
        total_cnt++;
        if (lu_b !== 2'd3 || lu_a !== 16'(m_lu) || m_lu < 5)
            $display("FAIL lu_saturate got %0d/%0d exp 3/%0d", lu_b, lu_a, m_lu);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [4:0] exp_c;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 59) == 0);
            rs_id     = 5'($urandom_range(0, 3));
            rt_id     = 5'($urandom_range(0, 3));
            rt_ex     = 5'($urandom_range(0, 3));
            uses_rt   = 1'($urandom);
            mem_read  = 1'($urandom);
            br        = ($urandom_range(0, 3) == 0);
            jmp       = ($urandom_range(0, 5) == 0);
            mem_req   = ($urandom_range(0, 2) == 0) || (n >= 300 && n < 380);
            mem_ready = ($urandom_range(0, 1) == 0) && !(n >= 300 && n < 380);
            #1;
            exp_c = model_ctrl();
            total_cnt++;
            if ({ctrl_a, ctrl_b} !== {exp_c, exp_c})
                $display("FAIL rand_ctrl@%0d got %b/%b exp %b", n, ctrl_a, ctrl_b, exp_c);
            else pass_cnt++;
            tick();
            total_cnt++;
            if ({lu_a, fl_a, mw_a, to_a} !== {16'(satc(m_lu, 16)), 16'(satc(m_fl, 16)),
                                              16'(satc(m_mw, 16)), m_to_a} ||
                {lu_b, fl_b, mw_b, to_b} !== {2'(satc(m_lu, 2)), 2'(satc(m_fl, 2)),
                                              2'(satc(m_mw, 2)), m_to_b})
                $display("FAIL rand_state@%0d got %0d %0d %0d %b / %0d %0d %0d %b exp %0d %0d %0d %b/%b",
                         n, lu_a, fl_a, mw_a, to_a, lu_b, fl_b, mw_b, to_b,
                         m_lu, m_fl, m_mw, m_to_a, m_to_b);
            else pass_cnt++;
        end
    endtask

    initial begin
        m_lu = 0; m_fl = 0; m_mw = 0; m_run = 0; m_to_a = 0; m_to_b = 0;
        drive_idle();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch_vs_load_use();
        test_mem_wait();
        test_ready_first();
        test_all_three();
        test_timeout();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
